// File: rtl/btn_led_pkg.sv
// Shared types and helpers for the push-button to LED mode controller.
package btn_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    BTN_IDLE = 2'd0,
    BTN_HELD = 2'd1,
    BTN_LONG = 2'd2
  } btn_state_e;

  function automatic mode_e mode_next(input mode_e m);
    case (m)
      MODE_OFF:  return MODE_ON;
      MODE_ON:   return MODE_SLOW;
      MODE_SLOW: return MODE_FAST;
      default:   return MODE_OFF;
    endcase
  endfunction

  function automatic logic ld_level(input mode_e m, input logic phase);
    case (m)
      MODE_OFF: return 1'b0;
      MODE_ON:  return 1'b1;
      default:  return phase;
    endcase
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchronizer followed by a hold-time debouncer; the output only
// follows the synced input after it has held a new level for DEBOUNCE_CYCLES.
module sync_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 125000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic stable_o
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Any cycle where the synced level matches the accepted one restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = synced;
      else                   cnt_d    = cnt_q + CW'(1);
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/btn_led_mode_ctrl.sv
// BTN0 -> LD0 controller: debounced button, short/long press classification,
// four-mode LED state machine with SLOW/FAST blink generator.
module btn_led_mode_ctrl
  import btn_led_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 125000,
  parameter int unsigned LONG_PRESS_CYCLES = 125000000,
  parameter int unsigned SLOW_HALF_CYCLES  = 62500000,
  parameter int unsigned FAST_HALF_CYCLES  = 15625000
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       BTN0,
  output logic       LD0,
  output logic       BTN_STABLE,
  output logic       PRESS_PULSE,
  output logic [1:0] MODE
);

  localparam int unsigned   HW        = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam int unsigned   BLINK_MAX = (SLOW_HALF_CYCLES > FAST_HALF_CYCLES) ?
                                        SLOW_HALF_CYCLES : FAST_HALF_CYCLES;
  localparam int unsigned   BW        = $clog2(BLINK_MAX + 1);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF_CYCLES - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF_CYCLES - 1);

  logic          stable, stable_prev_q;
  logic          rise, fall;
  logic          pulse_q;
  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  mode_e         mode_q, mode_d;
  logic [BW-1:0] blink_q, blink_d, half_last;
  logic          phase_q, phase_d;
  logic          ld_q;

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk_i   (SYS_CLK),
    .rst_ni  (RST_N),
    .din_i   (BTN0),
    .stable_o(stable)
  );

  assign rise = stable & ~stable_prev_q;
  assign fall = ~stable & stable_prev_q;

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      stable_prev_q <= 1'b0;
      pulse_q       <= 1'b0;
      state_q       <= BTN_IDLE;
      hold_q        <= '0;
      mode_q        <= MODE_OFF;
      blink_q       <= '0;
      phase_q       <= 1'b1;
      ld_q          <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      pulse_q       <= rise;
      state_q       <= state_d;
      hold_q        <= hold_d;
      mode_q        <= mode_d;
      blink_q       <= blink_d;
      phase_q       <= phase_d;
      ld_q          <= ld_level(mode_q, phase_q);
    end
  end

  // Reaching the hold threshold wins over a simultaneous release: that press is long.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    case (state_q)
      BTN_IDLE: begin
        if (rise) begin
          state_d = BTN_HELD;
          hold_d  = '0;
        end
      end
      BTN_HELD: begin
        hold_d = hold_q + HW'(1);
        if (hold_d == HOLD_LAST) begin
          mode_d  = MODE_OFF;
          state_d = fall ? BTN_IDLE : BTN_LONG;
        end else if (fall) begin
          mode_d  = mode_next(mode_q);
          state_d = BTN_IDLE;
        end
      end
      BTN_LONG: begin
        if (fall) state_d = BTN_IDLE;
      end
      default: state_d = BTN_IDLE;
    endcase
  end

  assign half_last = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

  // A mode change restarts the blink so the LED starts each blink mode lit.
  always_comb begin
    blink_d = '0;
    phase_d = phase_q;
    if (mode_d != mode_q) begin
      phase_d = 1'b1;
    end else if (mode_q == MODE_SLOW || mode_q == MODE_FAST) begin
      if (blink_q == half_last) phase_d = ~phase_q;
      else                      blink_d = blink_q + BW'(1);
    end
  end

  assign LD0         = ld_q;
  assign BTN_STABLE  = stable;
  assign PRESS_PULSE = pulse_q;
  assign MODE        = mode_q;

endmodule
